// File: rtl/syncn_encoder_if.sv
// JESD204B receiver SYNC~ link-control bundle: frame tick, multiframe length, sync/error requests and the SYNC~ status outputs.
// Latency: none. This file holds wiring only.
// Backpressure: none. Every signal is a level or a single-cycle pulse, with no handshake.
//
// Signals:
//   frame_clk     : one-cycle frame tick
//   i_K           : frames per multiframe minus 1
//   i_cgs_done    : code group sync achieved on all lanes (level)
//   i_resync_req  : link re-initialisation request (pulse)
//   i_err         : error to report (pulse)
//   o_sync_n      : SYNC~ line, active low
//   o_state       : 0 SYNC_REQ, 1 WAIT_LMFC, 2 LINK, 3 ERR_PULSE
//   o_frame_pos   : frame index within the multiframe
//   o_err_dropped : one-cycle pulse when an error report is discarded
// Modports: master drives the requests and observes SYNC~; slave is the encoder.
interface syncn_encoder_if;
    logic       frame_clk;
    logic [4:0] i_K;
    logic       i_cgs_done;
    logic       i_resync_req;
    logic       i_err;
    logic       o_sync_n;
    logic [1:0] o_state;
    logic [4:0] o_frame_pos;
    logic       o_err_dropped;

    modport master (
        output frame_clk, i_K, i_cgs_done, i_resync_req, i_err,
        input  o_sync_n, o_state, o_frame_pos, o_err_dropped
    );

    modport slave (
        input  frame_clk, i_K, i_cgs_done, i_resync_req, i_err,
        output o_sync_n, o_state, o_frame_pos, o_err_dropped
    );
endinterface

// File: rtl/syncn_encoder.sv
// JESD204B receiver SYNC~ generator. It requests sync, releases SYNC~ on a multiframe boundary, and reports errors as SYNC~ pulses.
// Latency: all outputs are registered and change on the clk edge that samples the causing input (1 cycle).
// Backpressure: none. An i_err that cannot start a pulse is discarded and flagged on o_err_dropped. Errors are never queued.
//
// Ports:
//   clk   : device clock. Every register uses its rising edge.
//   rst_n : asynchronous reset, active low
//   lnk   : syncn_encoder_if.slave, carrying the frame tick, K, requests and SYNC~ status
// Parameters:
//   FRAMES_REQ_MIN : minimum frame ticks SYNC~ stays low per request (5..15)
//   FRAMES_ERR     : length of an error-report pulse in frame ticks (1..4)
// Build option:
//   SYNCN_ERR_REPORT_EN : when defined, adds the ERR_PULSE state and error reporting.
//                         When undefined, i_err is ignored and o_err_dropped is held at 0.
module syncn_encoder #(
    parameter int unsigned FRAMES_REQ_MIN = 6,
    parameter int unsigned FRAMES_ERR     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    syncn_encoder_if.slave  lnk
);

`ifdef SYNCN_ERR_REPORT_EN
    typedef enum logic [1:0] {
        S_SYNC_REQ  = 2'd0,
        S_WAIT_LMFC = 2'd1,
        S_LINK      = 2'd2,
        S_ERR_PULSE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_SYNC_REQ  = 2'd0,
        S_WAIT_LMFC = 2'd1,
        S_LINK      = 2'd2
    } state_t;
`endif

    localparam logic [3:0] REQ_MIN = 4'(FRAMES_REQ_MIN);

    state_t     state_q;
    logic       sync_n_q;
    logic [4:0] frame_pos_q;
    logic [3:0] req_cnt_q;

    // The last frame of the multiframe is ticking. This is the only point where SYNC~ may be released from the alignment wait.
    logic lmfc_wrap;
    // Link loss condition: an explicit resync request, or code group sync is no longer held.
    logic link_drop;
    // The request counter runs only while SYNC~ is being held low for a sync request.
    logic req_counting;

    assign lmfc_wrap    = lnk.frame_clk && (frame_pos_q == lnk.i_K);
    assign link_drop    = lnk.i_resync_req || !lnk.i_cgs_done;
    assign req_counting = (state_q == S_SYNC_REQ) || (state_q == S_WAIT_LMFC);

`ifdef SYNCN_ERR_REPORT_EN
    localparam logic [2:0] ERR_LEN = 3'(FRAMES_ERR);

    logic [2:0] err_cnt_q;
    logic       err_dropped_q;
    // An error is accepted only in LINK when the link is not being torn down on the same cycle. Any other i_err is discarded.
    logic       err_accept;

    assign err_accept = (state_q == S_LINK) && !link_drop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_SYNC_REQ;
            sync_n_q      <= 1'b0;
            frame_pos_q   <= 5'd0;
            req_cnt_q     <= 4'd0;
`ifdef SYNCN_ERR_REPORT_EN
            err_cnt_q     <= 3'd0;
            err_dropped_q <= 1'b0;
`endif
        end else begin
            // Free-running multiframe position. FSM activity never clears it.
            // If K shrinks below the current position, the counter runs up through 31 and wraps to 0.
            if (lnk.frame_clk) begin
                frame_pos_q <= lmfc_wrap ? 5'd0 : frame_pos_q + 5'd1;
            end

            // The request counter saturates so a long wait cannot wrap it back below the minimum.
            if (lnk.frame_clk && req_counting && (req_cnt_q != REQ_MIN)) begin
                req_cnt_q <= req_cnt_q + 4'd1;
            end

            case (state_q)
                S_SYNC_REQ: begin
                    sync_n_q <= 1'b0;
                    if (lnk.i_cgs_done && (req_cnt_q == REQ_MIN)) begin
                        state_q <= S_WAIT_LMFC;
                    end
                end

                S_WAIT_LMFC: begin
                    // Going back to SYNC_REQ keeps req_cnt. The minimum request length is already met, so the
                    // link can come up again at the next multiframe boundary.
                    if (!lnk.i_cgs_done) begin
                        state_q  <= S_SYNC_REQ;
                        sync_n_q <= 1'b0;
                    end else if (lmfc_wrap) begin
                        state_q  <= S_LINK;
                        sync_n_q <= 1'b1;
                    end
                end

                S_LINK: begin
                    if (link_drop) begin
                        state_q   <= S_SYNC_REQ;
                        sync_n_q  <= 1'b0;
                        req_cnt_q <= 4'd0;
                    end
`ifdef SYNCN_ERR_REPORT_EN
                    else if (lnk.i_err) begin
                        state_q   <= S_ERR_PULSE;
                        sync_n_q  <= 1'b0;
                        err_cnt_q <= 3'd0;
                    end
`endif
                end

`ifdef SYNCN_ERR_REPORT_EN
                S_ERR_PULSE: begin
                    if (link_drop) begin
                        state_q   <= S_SYNC_REQ;
                        sync_n_q  <= 1'b0;
                        req_cnt_q <= 4'd0;
                    end else if (lnk.frame_clk) begin
                        err_cnt_q <= err_cnt_q + 3'd1;
                        // Release on the frame tick that completes the pulse.
                        if ((err_cnt_q + 3'd1) == ERR_LEN) begin
                            state_q  <= S_LINK;
                            sync_n_q <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state_q  <= S_SYNC_REQ;
                    sync_n_q <= 1'b0;
                end
            endcase

`ifdef SYNCN_ERR_REPORT_EN
            err_dropped_q <= lnk.i_err && !err_accept;
`endif
        end
    end

    assign lnk.o_sync_n    = sync_n_q;
    assign lnk.o_state     = state_q;
    assign lnk.o_frame_pos = frame_pos_q;

`ifdef SYNCN_ERR_REPORT_EN
    assign lnk.o_err_dropped = err_dropped_q;
`else
    logic unused_err;
    assign unused_err        = lnk.i_err;
    assign lnk.o_err_dropped = 1'b0;
`endif

    // SYNC~ is high in LINK and only in LINK.
    a_sync_n_tracks_link: assert property (
        @(posedge clk) disable iff (!rst_n) sync_n_q == (state_q == S_LINK));

    // The request counter never goes past its saturation value.
    a_req_cnt_saturates: assert property (
        @(posedge clk) disable iff (!rst_n) req_cnt_q <= REQ_MIN);

endmodule

// File: tb/tb_syncn_encoder.sv
module tb_syncn_encoder;
    localparam int REQ  = 6;
    localparam int ERRN = 2;
`ifdef SYNCN_ERR_REPORT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    syncn_encoder_if sif();

    syncn_encoder #(.FRAMES_REQ_MIN(REQ), .FRAMES_ERR(ERRN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lnk   (sif)
    );

    typedef struct packed {
        logic       sync_n;
        logic [1:0] state;
        logic [4:0] pos;
        logic       drop;
    } exp_t;

    exp_t scb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model. Modes: 0 request, 1 alignment wait, 2 link up, 3 error pulse.
    int m_mode = 0;
    int m_pos  = 0;
    int m_req  = 0;
    int m_errf = 0;
    bit m_drop = 1'b0;

    int fper = 3;
    int fcnt = 0;

    function automatic void model_reset();
        m_mode = 0; m_pos = 0; m_req = 0; m_errf = 0; m_drop = 1'b0;
    endfunction

    function automatic void model_step();
        bit tick, wrap, cgs, rs, err, taken;
        int nmode, req_n;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        tick  = (sif.frame_clk === 1'b1);
        cgs   = (sif.i_cgs_done === 1'b1);
        rs    = (sif.i_resync_req === 1'b1);
        err   = (sif.i_err === 1'b1);
        wrap  = tick && (m_pos == int'(sif.i_K));
        nmode = m_mode;
        taken = 1'b0;
        // The request counter counts frame ticks while SYNC~ is held for a request, up to the minimum.
        req_n = m_req;
        if (tick && (m_mode == 0 || m_mode == 1) && m_req < REQ) req_n = m_req + 1;
        case (m_mode)
            0: if (cgs && m_req == REQ) nmode = 1;
            1: begin
                if (!cgs) nmode = 0;
                else if (wrap) nmode = 2;
            end
            2: begin
                if (rs || !cgs) begin nmode = 0; req_n = 0; end
                else if (ERR_EN && err) begin nmode = 3; m_errf = 0; taken = 1'b1; end
            end
            default: begin
                if (rs || !cgs) begin nmode = 0; req_n = 0; end
                else if (tick) begin
                    m_errf = m_errf + 1;
                    if (m_errf == ERRN) nmode = 2;
                end
            end
        endcase
        m_drop = ERR_EN && err && !taken;
        if (tick) m_pos = wrap ? 0 : (m_pos + 1) % 32;
        m_mode = nmode;
        m_req  = req_n;
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: on each falling edge it pops the expected response and compares it with the DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        if (scb.size() > 0) begin
            e = scb.pop_front();
            chk("sync_n",      5'(sif.o_sync_n),      5'(e.sync_n));
            chk("state",       5'(sif.o_state),       5'(e.state));
            chk("frame_pos",   sif.o_frame_pos,       e.pos);
            chk("err_dropped", 5'(sif.o_err_dropped), 5'(e.drop));
        end
    end

    // One clock: step the model at the edge, push its prediction, then drive the next inputs.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        model_step();
        e.sync_n = (m_mode == 2);
        e.state  = 2'(m_mode);
        e.pos    = 5'(m_pos);
        e.drop   = m_drop;
        scb.push_back(e);
        #2;
        fcnt = fcnt + 1;
        if (fcnt >= fper) fcnt = 0;
        sif.frame_clk    = (fcnt == 0);
        sif.i_err        = 1'b0;
        sif.i_resync_req = 1'b0;
    endtask

    task automatic wait_mode(input int target, input int budget, input string name);
        for (int i = 0; i < budget && m_mode != target; i++) cyc();
        if (m_mode != target) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: mode %0d expected %0d", name, m_mode, target);
        end
    endtask

    // Asserts reset mid-cycle and checks, before any clock edge, that the outputs have already been forced.
    task automatic async_reset(input string name);
        #1;
        rst_n = 1'b0;
        #1;
        chk({name, "_sync_n"}, 5'(sif.o_sync_n), 5'd0);
        chk({name, "_state"},  5'(sif.o_state),  5'd0);
        chk({name, "_pos"},    sif.o_frame_pos,  5'd0);
        chk({name, "_drop"},   5'(sif.o_err_dropped), 5'd0);
        scb.delete();
        model_reset();
    endtask

    initial begin
        sif.frame_clk    = 1'b0;
        sif.i_K          = 5'd3;
        sif.i_cgs_done   = 1'b0;
        sif.i_resync_req = 1'b0;
        sif.i_err        = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;

        // Basic link-up with K=4.
        repeat (2 * fper) cyc();
        sif.i_cgs_done = 1'b1;
        wait_mode(2, 300, "basic_linkup");
        repeat (10) cyc();

        // Error pulse, then a second error inside the pulse.
        sif.i_err = 1'b1;
        cyc();
        repeat (2) cyc();
        sif.i_err = 1'b1;
        cyc();
        repeat (20) cyc();

        // Resync and error on the same cycle.
        sif.i_resync_req = 1'b1;
        sif.i_err        = 1'b1;
        cyc();
        wait_mode(2, 300, "resync_priority");

        // Code group sync loss during the alignment wait.
        sif.i_resync_req = 1'b1;
        cyc();
        wait_mode(1, 300, "reach_wait");
        cyc();
        sif.i_cgs_done = 1'b0;
        repeat (5) cyc();
        sif.i_cgs_done = 1'b1;
        wait_mode(2, 300, "cgs_loss_recover");
        repeat (5) cyc();

        // Late code group sync with K=32.
        async_reset("rst_linkup");
        sif.i_K        = 5'd31;
        sif.i_cgs_done = 1'b0;
        fper           = 2;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (10 * fper) cyc();
        sif.i_cgs_done = 1'b1;
        wait_mode(2, 400, "late_cgs");
        repeat (5) cyc();

        // Reset in the middle of an error pulse, or in the link when error reporting is off.
        sif.i_K = 5'd3;
        fper    = 4;
        sif.i_err = 1'b1;
        cyc();
        cyc();
        async_reset("rst_midpulse");
        repeat (2) cyc();
        rst_n = 1'b1;

        // Randomised segments, each with its own K and frame period.
        for (int seg = 0; seg < 5; seg++) begin
            async_reset("rst_seg");
            sif.i_K        = 5'($urandom_range(0, 31));
            fper           = $urandom_range(1, 4);
            sif.i_cgs_done = 1'b1;
            cyc();
            rst_n = 1'b1;
            for (int i = 0; i < 900; i++) begin
                if ($urandom_range(0, 199) == 0) sif.i_cgs_done = ~sif.i_cgs_done;
                sif.i_err        = ($urandom_range(0, 9) == 0);
                sif.i_resync_req = ($urandom_range(0, 149) == 0);
                cyc();
            end
        end

        cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
